// File: rtl/alu_pkg.sv
// Shared types for the registered ALU with iterative multiply/divide unit.
// Holds op codes, the control FSM states and the M-op decode helper.
package alu_pkg;

   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SLL    = 5'd1,
      OP_SLT    = 5'd2,
      OP_SLTU   = 5'd3,
      OP_XOR    = 5'd4,
      OP_SRL    = 5'd5,
      OP_SRA    = 5'd6,
      OP_AND    = 5'd7,
      OP_OR     = 5'd8,
      OP_SUB    = 5'd9,
      OP_MUL    = 5'd16,
      OP_MULH   = 5'd17,
      OP_MULHSU = 5'd18,
      OP_MULHU  = 5'd19,
      OP_DIV    = 5'd20,
      OP_DIVU   = 5'd21,
      OP_REM    = 5'd22,
      OP_REMU   = 5'd23
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int OP_IS_MDU = 4;

   // Codes 24..31 also have bit 4 set but are unused single-cycle codes.
   function automatic logic op_is_mdu(input logic [4:0] op);
      return op[OP_IS_MDU] && !op[3];
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative RV32M datapath: radix-2 shift-add multiply and restoring divide.
// Captures operands on start, sets up magnitudes, runs WORD_LENGTH steps, raises done.
module mdu_iter
   import alu_pkg::*;
#(
   parameter int WORD_LENGTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   start,
   input  logic [2:0]             op_sel,
   input  logic [WORD_LENGTH-1:0] in_1,
   input  logic [WORD_LENGTH-1:0] in_2,
   output logic                   done,
   output logic [WORD_LENGTH-1:0] result
);

   localparam int W       = WORD_LENGTH;
   localparam int SHAMT_W = $clog2(W);
   localparam logic [SHAMT_W:0] LAST_STEP = (SHAMT_W + 1)'(W + 1);
   localparam logic [SHAMT_W:0] STEP_ONE  = (SHAMT_W + 1)'(1);

   logic             busy;
   logic [SHAMT_W:0] step;
   logic [2:0]       op_r;
   logic [W-1:0]     a_r, b_r;
   logic [2*W-1:0]   acc;
   logic             neg_q, neg_r, b_zero;

   op_e            op_full;
   logic           a_signed, b_signed, sa, sb, is_div, fits;
   logic [W-1:0]   abs_a, abs_b, addend, quot, rem;
   logic [W:0]     mul_sum, rem_shift;
   logic [2*W-1:0] mul_next, div_next, prod;

   assign op_full = op_e'({2'b10, op_r});
   assign is_div  = op_r[2];

   always_comb begin
      a_signed = op_full inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
      b_signed = op_full inside {OP_MULH, OP_DIV, OP_REM};
   end

   assign sa    = a_signed && a_r[W-1];
   assign sb    = b_signed && b_r[W-1];
   assign abs_a = sa ? -a_r : a_r;
   assign abs_b = sb ? -b_r : b_r;

   // acc = {high/remainder, low/quotient}; the multiplier shifts out of the low half.
   assign addend   = acc[0] ? b_r : '0;
   assign mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, addend};
   assign mul_next = {mul_sum, acc[W-1:1]};

   assign rem_shift = {acc[2*W-1:W], acc[W-1]};
   assign fits      = rem_shift >= {1'b0, b_r};
   assign div_next  = fits ? {W'(rem_shift - {1'b0, b_r}), acc[W-2:0], 1'b1}
                           : {rem_shift[W-1:0], acc[W-2:0], 1'b0};

   assign prod = neg_q ? -acc : acc;
   assign quot = acc[W-1:0];
   assign rem  = acc[2*W-1:W];

   always_comb begin
      result = '0;
      case (op_full)
         OP_MUL:                       result = prod[W-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*W-1:W];
         OP_DIV, OP_DIVU:              result = b_zero ? '1 : (neg_q ? -quot : quot);
         OP_REM, OP_REMU:              result = neg_r ? -rem : rem;
         default:                      result = '0;
      endcase
   end

   assign done = busy && (step == LAST_STEP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy   <= 1'b0;
         step   <= '0;
         op_r   <= '0;
         a_r    <= '0;
         b_r    <= '0;
         acc    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         b_zero <= 1'b0;
      end else if (flush) begin
         busy <= 1'b0;
      end else if (start) begin
         busy <= 1'b1;
         step <= '0;
         op_r <= op_sel;
         a_r  <= in_1;
         b_r  <= in_2;
      end else if (busy) begin
         if (step == '0) begin
            acc    <= {{W{1'b0}}, abs_a};
            b_r    <= abs_b;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            b_zero <= (b_r == '0);
            step   <= step + STEP_ONE;
         end else if (step == LAST_STEP) begin
            busy <= 1'b0;
         end else begin
            acc  <= is_div ? div_next : mul_next;
            step <= step + STEP_ONE;
         end
      end
   end

endmodule

// File: rtl/alu_mdu.sv
// Registered execute-stage ALU: single-cycle base ops plus optional iterative MUL/DIV.
// Handshake: op accepted on a rising edge with in_valid && in_ready; out_valid pulses one cycle per result.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int WORD_LENGTH = 32,
   parameter bit ENABLE_MDU  = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4:0]             op,
   input  logic [WORD_LENGTH-1:0] in_1,
   input  logic [WORD_LENGTH-1:0] in_2,
   output logic                   out_valid,
   output logic [WORD_LENGTH-1:0] alu_out,
   output logic                   carry_out,
   output logic                   zero,
   output logic                   sign
);

   localparam int W       = WORD_LENGTH;
   localparam int SHAMT_W = $clog2(W);

   state_e             state, state_next;
   logic               accept, is_mdu, start_mdu, mdu_done, base_carry;
   logic [W-1:0]       mdu_result, base_result;
   logic [SHAMT_W-1:0] shamt;
   logic [W:0]         add_sum, sub_sum;

   assign in_ready  = (state == IDLE);
   assign accept    = in_valid && in_ready && !flush;
   assign is_mdu    = ENABLE_MDU && op_is_mdu(op);
   assign start_mdu = accept && is_mdu;

   assign shamt   = in_2[SHAMT_W-1:0];
   assign add_sum = {1'b0, in_1} + {1'b0, in_2};
   assign sub_sum = {1'b0, in_1} + {1'b0, ~in_2} + {{W{1'b0}}, 1'b1};

   always_comb begin
      base_result = '0;
      base_carry  = 1'b0;
      case (op_e'(op))
         OP_ADD:  begin base_result = add_sum[W-1:0]; base_carry = add_sum[W]; end
         OP_SUB:  begin base_result = sub_sum[W-1:0]; base_carry = sub_sum[W]; end
         OP_SLL:  base_result = in_1 << shamt;
         OP_SRL:  base_result = in_1 >> shamt;
         OP_SRA:  base_result = W'($signed(in_1) >>> shamt);
         OP_SLT:  base_result = {{(W-1){1'b0}}, $signed(in_1) < $signed(in_2)};
         OP_SLTU: base_result = {{(W-1){1'b0}}, in_1 < in_2};
         OP_XOR:  base_result = in_1 ^ in_2;
         OP_AND:  base_result = in_1 & in_2;
         OP_OR:   base_result = in_1 | in_2;
         default: base_result = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (start_mdu) state_next = op[2] ? DIV : MUL;
         MUL, DIV: begin
            if (flush)         state_next = IDLE;
            else if (mdu_done) state_next = DONE;
         end
         DONE:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // A flushed M op keeps the previous result and flags on the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_out   <= '0;
         carry_out <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (accept && !is_mdu) begin
            alu_out   <= base_result;
            carry_out <= base_carry;
            out_valid <= 1'b1;
         end else if ((state == MUL || state == DIV) && !flush && mdu_done) begin
            alu_out   <= mdu_result;
            carry_out <= 1'b0;
            out_valid <= 1'b1;
         end
      end
   end

   assign zero = (alu_out == '0);
   assign sign = alu_out[W-1];

   generate
      if (ENABLE_MDU) begin : g_mdu
         mdu_iter #(.WORD_LENGTH(W)) u_mdu (
            .clk    (clk),
            .rst_n  (rst_n),
            .flush  (flush),
            .start  (start_mdu),
            .op_sel (op[2:0]),
            .in_1   (in_1),
            .in_2   (in_2),
            .done   (mdu_done),
            .result (mdu_result)
         );
      end else begin : g_no_mdu
         assign mdu_done   = 1'b0;
         assign mdu_result = '0;
      end
   endgenerate

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed scenarios plus random ops checked
// against an arithmetic reference model; one summary line at the end.
module tb_alu_mdu;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n, flush, in_valid, in_ready;
   logic [4:0]   op;
   logic [W-1:0] in_1, in_2, alu_out;
   logic         out_valid, carry_out, zero, sign;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] last_exp = '0;
   logic [4:0]   op_tab [20] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
                                 5'd12, 5'd27};

   alu_mdu #(.WORD_LENGTH(W), .ENABLE_MDU(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .in_1      (in_1),
      .in_2      (in_2),
      .out_valid (out_valid),
      .alu_out   (alu_out),
      .carry_out (carry_out),
      .zero      (zero),
      .sign      (sign)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard check
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks = n_checks + 1;
      assert (obs === expv) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // reference model: plain integer arithmetic on 64-bit values
   function automatic void model(input logic [4:0] opv, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output logic [W-1:0] r,
                                 output logic c);
      longint      sa, sb;
      logic [63:0] ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = '0;
      c  = 1'b0;
      p  = '0;
      case (opv)
         5'd0:  begin p = ua + ub; r = p[31:0]; c = p[32]; end
         5'd9:  begin r = a - b; c = (a >= b); end
         5'd1:  r = a << b[4:0];
         5'd5:  r = a >> b[4:0];
         5'd6:  begin p = sa >>> b[4:0]; r = p[31:0]; end
         5'd2:  r = (sa < sb) ? 32'd1 : 32'd0;
         5'd3:  r = (a < b) ? 32'd1 : 32'd0;
         5'd4:  r = a ^ b;
         5'd7:  r = a & b;
         5'd8:  r = a | b;
         5'd16: begin p = ua * ub; r = p[31:0]; end
         5'd17: begin p = sa * sb; r = p[63:32]; end
         5'd18: begin p = sa * longint'(ub); r = p[63:32]; end
         5'd19: begin p = ua * ub; r = p[63:32]; end
         5'd20: if (b == 0) r = '1; else begin p = sa / sb; r = p[31:0]; end
         5'd21: if (b == 0) r = '1; else r = a / b;
         5'd22: if (b == 0) r = a; else begin p = sa % sb; r = p[31:0]; end
         5'd23: if (b == 0) r = a; else r = a % b;
         default: r = '0;
      endcase
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 4))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         default: return $urandom();
      endcase
   endfunction

   // driver: issue one op, wait for its result, check value, flags and timing
   task automatic run_op(input logic [4:0] op_v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input string tag);
      logic [W-1:0] er, exp_r;
      logic         ec;
      bit           is_m, low_ok;
      int           lat, exp_lat, waited;
      model(op_v, a, b, er, ec);
      is_m    = (op_v >= 5'd16) && (op_v <= 5'd23);
      exp_lat = is_m ? W + 2 : 0;
      exp_q.push_back(er);
      @(negedge clk);
      waited = 0;
      while (!in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_ready_in"}, in_ready, 1);
      op = op_v; in_1 = a; in_2 = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      low_ok = 1'b1;
      while (!out_valid && lat < 100) begin
         if (in_ready) low_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      exp_r = exp_q.pop_front();
      last_exp = exp_r;
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_result"}, alu_out, exp_r);
      check({tag, "_carry"}, carry_out, ec);
      check({tag, "_zero"}, zero, exp_r == '0);
      check({tag, "_sign"}, sign, exp_r[W-1]);
      check({tag, "_ready_at_out"}, in_ready, !is_m);
      if (is_m) check({tag, "_ready_low_busy"}, low_ok, 1);
      @(posedge clk); #1;
      check({tag, "_pulse_one"}, out_valid, 0);
   endtask

   initial begin
      int stray;
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0; in_1 = '0; in_2 = '0;

      // reset values, asynchronous (no clock edge before the sample)
      #2 rst_n = 1'b0;
      #1;
      check("rst_alu_out", alu_out, 0);
      check("rst_zero", zero, 1);
      check("rst_sign", sign, 0);
      check("rst_carry", carry_out, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 1: three base ops on consecutive cycles
      @(negedge clk);
      op = 5'd0; in_1 = 32'hFFFF_FFFF; in_2 = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      check("t1_add_valid", out_valid, 1);
      check("t1_add_result", alu_out, 32'h0);
      check("t1_add_carry", carry_out, 1);
      check("t1_add_zero", zero, 1);
      op = 5'd9; in_1 = 32'd5; in_2 = 32'd7;
      @(posedge clk); #1;
      check("t1_sub_valid", out_valid, 1);
      check("t1_sub_result", alu_out, 32'hFFFF_FFFE);
      check("t1_sub_carry", carry_out, 0);
      check("t1_sub_sign", sign, 1);
      op = 5'd6; in_1 = 32'h8000_0000; in_2 = 32'd4;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("t1_sra_valid", out_valid, 1);
      check("t1_sra_result", alu_out, 32'hF800_0000);
      @(posedge clk); #1;
      check("t1_idle_valid", out_valid, 0);

      // 2: multiply
      run_op(5'd16, 32'hFFFF_FFFD, 32'd7, "t2_mul");
      check("t2_mul_const", alu_out, 32'hFFFF_FFEB);
      run_op(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t2_mulhu");
      check("t2_mulhu_const", alu_out, 32'hFFFF_FFFE);

      // 3: divide, remainder, divide by zero
      run_op(5'd20, 32'hFFFF_FFF9, 32'd2, "t3_div");
      check("t3_div_const", alu_out, 32'hFFFF_FFFD);
      run_op(5'd22, 32'hFFFF_FFF9, 32'd2, "t3_rem");
      check("t3_rem_const", alu_out, 32'hFFFF_FFFF);
      run_op(5'd21, 32'd7, 32'd0, "t3_divu0");
      check("t3_divu0_const", alu_out, 32'hFFFF_FFFF);
      run_op(5'd23, 32'd7, 32'd0, "t3_remu0");
      check("t3_remu0_const", alu_out, 32'd7);
      run_op(5'd20, 32'hFFFF_FFF9, 32'd0, "t3_div0");
      run_op(5'd22, 32'hFFFF_FFF9, 32'd0, "t3_rem0");

      // flush in IDLE cancels the same-cycle accept
      @(negedge clk);
      op = 5'd0; in_1 = 32'd10; in_2 = 32'd20; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      check("fi_out_valid", out_valid, 0);
      check("fi_alu_hold", alu_out, last_exp);
      check("fi_in_ready", in_ready, 1);

      // 4: signed overflow
      run_op(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, "t4_div_ovf");
      check("t4_div_const", alu_out, 32'h8000_0000);
      run_op(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, "t4_rem_ovf");
      check("t4_rem_const", alu_out, 32'h0);
      run_op(5'd1, 32'd9, 32'd0, "t4_nonzero");

      // 5: flush 10 cycles into a DIV, then ADD
      @(negedge clk);
      op = 5'd20; in_1 = 32'd100; in_2 = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("t5_busy", in_ready, 0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("t5_ready_after", in_ready, 1);
      check("t5_no_valid", out_valid, 0);
      check("t5_alu_hold", alu_out, last_exp);
      run_op(5'd0, 32'd1, 32'd2, "t5_add");
      check("t5_add_const", alu_out, 32'd3);
      stray = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) stray++;
      end
      check("t5_no_stray", stray, 0);

      // 6: asynchronous reset in the middle of a MUL
      @(negedge clk);
      op = 5'd16; in_1 = 32'd1234; in_2 = 32'd5678; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t6_alu_out", alu_out, 0);
      check("t6_zero", zero, 1);
      check("t6_sign", sign, 0);
      check("t6_carry", carry_out, 0);
      check("t6_out_valid", out_valid, 0);
      check("t6_in_ready", in_ready, 1);
      stray = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (out_valid) stray++;
      end
      check("t6_no_valid_rst", stray, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(5'd16, 32'd1234, 32'd5678, "t6_after");

      // random ops against the model
      for (int i = 0; i < 30; i++) begin
         run_op(op_tab[$urandom_range(0, 19)], pick(), pick(), "rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, registered successor to the core ALU. Adds the RV32M multiply/divide/remainder ops as an iterative unit, with a valid/ready handshake so the datapath can stall on multi-cycle ops.
- Base integer ops complete with 1-cycle latency at full throughput. MUL/DIV-class ops take a fixed WORD_LENGTH+2 cycles.
- Sits in the execute stage between operand muxes and writeback; the control unit drives op and consumes out_valid.

Parameters:
WORD_LENGTH, 32, operand/result width; must be a power of two, >= 8
ENABLE_MDU, 1, 0 removes the multiply/divide unit; M ops then return 0 at 1-cycle latency
SHAMT_W, $clog2(WORD_LENGTH), localparam, shift-amount width

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous kill of any in-flight op
in_valid  input  1  operands and op valid
in_ready  output  1  unit can accept; high only in IDLE
op  input  5  operation code, see Behaviour
in_1  input  WORD_LENGTH  operand A / rs1
in_2  input  WORD_LENGTH  operand B / rs2
out_valid  output  1  one-cycle pulse, result valid
alu_out  output  WORD_LENGTH  result
carry_out  output  1  add carry / sub no-borrow; 0 for all other ops
zero  output  1  alu_out == 0
sign  output  1  alu_out[WORD_LENGTH-1]

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, alu_out=0, carry_out=0, zero=1, sign=0.
- Reset mid-operation aborts immediately; no out_valid is produced.
- Op codes:
  - Base ops: 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 SRA (true arithmetic, sign-filling), 7 AND, 8 OR, 9 SUB.
  - M ops: 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Unused codes return 0 at 1-cycle latency.
- Shifts use in_2[SHAMT_W-1:0]. All arithmetic wraps modulo 2^WORD_LENGTH.
- Handshake: an op is accepted on a rising edge where in_valid && in_ready.
- Base op accepted at edge k: alu_out and flags are registered at edge k, and out_valid is high for the following cycle. State stays IDLE, so back-to-back base ops run at 1 per cycle.
- M op accepted at edge k:
  - State goes to MUL or DIV; in_ready drops.
  - Edge k+1: operand setup (absolute values for signed variants, clear accumulators).
  - Edges k+2 .. k+W+1: one iteration each; MUL is radix-2 shift-add, DIV is radix-2 restoring.
  - Edge k+W+2: sign fix-up and result selection, alu_out registered; state goes to DONE.
  - Cycle after edge k+W+2: out_valid=1 for exactly one cycle, in_ready=0; state returns to IDLE on the next edge.
  - Total: out_valid is seen WORD_LENGTH+2 cycles after the cycle in which the op was accepted.
- Divide by zero: quotient = all ones; remainder = in_1. Same fixed latency.
- Signed overflow (most-negative / -1): quotient = in_1; remainder = 0. Same fixed latency.
- MULH/MULHSU/MULHU return the upper word of the 2W-bit product; MUL returns the lower word.
- Flags are registered with alu_out and hold their value between out_valid pulses.
- flush:
  - In MUL/DIV/DONE: go to IDLE at the next edge, suppress out_valid, hold alu_out.
  - In IDLE: the same-cycle accept is cancelled.
  - flush takes priority over in_valid.
- in_valid while busy is ignored; the master must hold it until it sees in_ready.

Decomposition:
- Package alu_pkg:
  - op_e enum with the codes above.
  - state_e (IDLE, MUL, DIV, DONE).
  - Helper constant OP_IS_MDU = op[4].
- Sub-module mdu_iter holds the iterative multiply/divide datapath: accumulator, shifted operand, counter, sign flags. It has start/done pins and is instantiated only when ENABLE_MDU=1.
- The base-op combinational datapath stays in the top module.

Test Plan (WORD_LENGTH=32):
1. Base ops at full rate: ADD 0xFFFFFFFF+1, then SUB 5-7, then SRA 0x80000000 by 4, on three consecutive cycles.
   -> out_valid three cycles running.
   -> Results: 0 with carry=1 and zero=1; 0xFFFFFFFE with carry=0 and sign=1; 0xF8000000.
2. MUL -3 * 7, then MULHU 0xFFFFFFFF * 0xFFFFFFFF.
   -> 0xFFFFFFEB and 0xFFFFFFFE.
   -> out_valid exactly 34 cycles after acceptance; in_ready low throughout.
3. DIV -7 / 2 and REM -7 / 2.
   -> 0xFFFFFFFD and 0xFFFFFFFF.
   -> DIVU 7/0 gives 0xFFFFFFFF; REMU 7/0 gives 7.
4. DIV 0x80000000 / 0xFFFFFFFF.
   -> 0x80000000; REM of the same operands gives 0.
5. Assert flush 10 cycles into a DIV, then issue ADD 1+2.
   -> No out_valid for the DIV; in_ready high the next cycle; ADD returns 3 one cycle after acceptance.
6. Drop rst_n mid-MUL.
   -> Outputs return immediately to reset values (no clock edge needed); no out_valid; a fresh op after reset release completes normally.
